// File: rtl/fisc_writeback_if.sv
// fisc_writeback_if: ALU, load, scoreboard-lookup and register-file write port bundle
interface fisc_writeback_if #(
  parameter int DATA_W = 64
);
  logic              alu_valid;
  logic              alu_ready;
  logic [5:0]        alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_wr;
  logic              alu_set_flags;
  logic [3:0]        alu_flags;
  logic              ld_issue;
  logic              ld_issue_ready;
  logic [5:0]        ld_issue_reg;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic [5:0]        chk_reg1;
  logic [5:0]        chk_reg2;
  logic              busy1;
  logic              busy2;
  logic              wr;
  logic [5:0]        wr_reg;
  logic [DATA_W-1:0] din;
  logic              set_flags;
  logic              flag_negative;
  logic              flag_zero;
  logic              flag_overflow;
  logic              flag_carry;
  modport master (
    output alu_valid, alu_reg, alu_data, alu_wr, alu_set_flags, alu_flags,
    output ld_issue, ld_issue_reg, ld_valid, ld_data, chk_reg1, chk_reg2,
    input  alu_ready, ld_issue_ready, ld_ready, busy1, busy2,
    input  wr, wr_reg, din, set_flags, flag_negative, flag_zero, flag_overflow, flag_carry
  );
  modport slave (
    input  alu_valid, alu_reg, alu_data, alu_wr, alu_set_flags, alu_flags,
    input  ld_issue, ld_issue_reg, ld_valid, ld_data, chk_reg1, chk_reg2,
    output alu_ready, ld_issue_ready, ld_ready, busy1, busy2,
    output wr, wr_reg, din, set_flags, flag_negative, flag_zero, flag_overflow, flag_carry
  );
endinterface

// File: rtl/fisc_writeback.sv
// fisc_writeback: merges ALU results and in-order load returns onto one registered register-file write with a pending-load scoreboard
module fisc_writeback #(
  parameter int DATA_W   = 64,
  parameter int LQ_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  fisc_writeback_if.slave  bus
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(LQ_DEPTH);
  logic [63:0]       busy_q, busy_d;
  logic [5:0]        tags_q [LQ_DEPTH];
  logic [5:0]        tags_d [LQ_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              wr_q, wr_d, set_flags_q, set_flags_d, out_is_load_q, out_is_load_d;
  logic [5:0]        wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [3:0]        flags_q, flags_d;
  logic              ld_issue_ready, ld_ready, alu_ready;
  logic              issue_acc, ret_acc, alu_acc;
  assign ld_issue_ready = (cnt_q < FULL) && !busy_q[bus.ld_issue_reg];
  assign ld_ready       = cnt_q != '0;
  assign ret_acc        = bus.ld_valid && ld_ready;
  assign alu_ready      = !ret_acc && !(bus.alu_wr && busy_q[bus.alu_reg]);
  assign issue_acc      = bus.ld_issue && ld_issue_ready;
  assign alu_acc        = bus.alu_valid && alu_ready;
  assign bus.ld_issue_ready = ld_issue_ready;
  assign bus.ld_ready       = ld_ready;
  assign bus.alu_ready      = alu_ready;
  assign bus.busy1          = busy_q[bus.chk_reg1];
  assign bus.busy2          = busy_q[bus.chk_reg2];
  assign bus.wr             = wr_q;
  assign bus.wr_reg         = wr_reg_q;
  assign bus.din            = din_q;
  assign bus.set_flags      = set_flags_q;
  assign {bus.flag_negative, bus.flag_zero, bus.flag_overflow, bus.flag_carry} = flags_q;
  // Tag FIFO and scoreboard: clear on load commit first so a same-index issue set wins
  always_comb begin
    tags_d = tags_q;
    busy_d = busy_q;
    wptr_d = issue_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d = ret_acc ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + (PW+1)'(issue_acc) - (PW+1)'(ret_acc);
    if (out_is_load_q) busy_d[wr_reg_q] = 1'b0;
    if (issue_acc) begin
      busy_d[bus.ld_issue_reg] = 1'b1;
      tags_d[wptr_q] = bus.ld_issue_reg;
    end
  end
  // Write-port arbitration: load return has fixed priority, flag-only ALU ops target r63
  always_comb begin
    wr_d          = ret_acc || (alu_acc && (bus.alu_wr || bus.alu_set_flags));
    set_flags_d   = alu_acc && bus.alu_set_flags;
    out_is_load_d = ret_acc;
    wr_reg_d      = ret_acc ? tags_q[rptr_q] :
                    alu_acc && bus.alu_wr ? bus.alu_reg :
                    alu_acc && bus.alu_set_flags ? 6'd63 : wr_reg_q;
    din_d         = ret_acc ? bus.ld_data : alu_acc && bus.alu_wr ? bus.alu_data : din_q;
    flags_d       = alu_acc && (bus.alu_wr || bus.alu_set_flags) ? bus.alu_flags : flags_q;
  end
  // State registers with synchronous reset discarding all outstanding loads
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      tags_q        <= '{default: '0};
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      wr_reg_q      <= '0;
      din_q         <= '0;
      set_flags_q   <= 1'b0;
      flags_q       <= '0;
      out_is_load_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      tags_q        <= tags_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      wr_reg_q      <= wr_reg_d;
      din_q         <= din_d;
      set_flags_q   <= set_flags_d;
      flags_q       <= flags_d;
      out_is_load_q <= out_is_load_d;
    end
  end
endmodule
